// File: rtl/pacman_pkg.sv
// ============================================================================
//  Module   : pacman_pkg
//  Purpose  : Direction encoding, direction type, controller state encoding and helpers
//  Revision : 1.0
// ============================================================================
`default_nettype none

package pacman_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_DOWN  = 2'd1;
    localparam dir_t DIR_LEFT  = 2'd2;
    localparam dir_t DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    function automatic dir_t opposite_dir(input dir_t d);
        case (d)
            DIR_UP:   opposite_dir = DIR_DOWN;
            DIR_DOWN: opposite_dir = DIR_UP;
            DIR_LEFT: opposite_dir = DIR_RIGHT;
            default:  opposite_dir = DIR_LEFT;
        endcase
    endfunction

    function automatic dir_t dir_from_onehot(input logic [3:0] oh);
        dir_from_onehot = DIR_UP;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) dir_from_onehot = dir_t'(i);
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/dir_ctrl_if.sv
// ============================================================================
//  Module   : dir_ctrl_if
//  Purpose  : Button/tick/wall inputs and heading/step outputs of the direction controller
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface dir_ctrl_if;
    import pacman_pkg::*;

    logic [3:0] btn;
    logic       move_tick;
    logic [3:0] wall;
    dir_t       heading;
    logic       moving;
    logic       step;
    logic       pend_valid;

    modport master (
        output btn, move_tick, wall,
        input  heading, moving, step, pend_valid
    );

    modport slave (
        input  btn, move_tick, wall,
        output heading, moving, step, pend_valid
    );

endinterface

`default_nettype wire

// File: rtl/dir_ctrl_rr_arb4.sv
// ============================================================================
//  Module   : rr_arb4
//  Purpose  : 4-way round-robin arbiter, one-hot grant, pointer moves to grant+1
//  Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb4 (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [3:0] request,
    output      logic [3:0] grant
);

    logic [1:0] r_ptr;
    logic [1:0] w_gidx;
    logic [1:0] w_idx;
    logic       w_found;

    always_comb begin
        grant   = 4'b0000;
        w_gidx  = r_ptr;
        w_idx   = r_ptr;
        w_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_idx = r_ptr + 2'(i);
            if (!w_found && request[w_idx]) begin
                grant[w_idx] = 1'b1;
                w_gidx       = w_idx;
                w_found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 2'd0;
        end else if (w_found) begin
            r_ptr <= w_gidx + 2'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dir_ctrl.sv
// ============================================================================
//  Module   : dir_ctrl
//  Purpose  : Buffers button turns and commits heading/step on movement decision ticks
//  Revision : 1.0
// ============================================================================
`default_nettype none

module dir_ctrl
    import pacman_pkg::*;
#(
    parameter int PEND_TICKS = 4
) (
    input wire logic   clk,
    input wire logic   rst,
    dir_ctrl_if.slave  bus
);

    localparam int c_AGE_W = $clog2(PEND_TICKS) + 1;
    localparam logic [c_AGE_W-1:0] c_AGE_LAST = c_AGE_W'(PEND_TICKS - 1);
    localparam logic [c_AGE_W-1:0] c_AGE_ONE  = c_AGE_W'(1);

    state_t               r_state, w_state_next;
    dir_t                 r_heading, w_heading_next;
    logic                 r_step, w_step_next;
    logic                 r_pend_valid, w_pend_valid_next;
    dir_t                 r_pend_dir, w_pend_dir_next;
    logic [c_AGE_W-1:0]   r_pend_age, w_pend_age_next;
    logic [3:0]           r_btn_q;
    logic [3:0]           w_rise;
    logic [3:0]           w_grant;
    logic                 w_wall_pend;
    logic                 w_wall_head;

    assign w_rise      = bus.btn & ~r_btn_q;
    assign w_wall_pend = bus.wall[r_pend_dir];
    assign w_wall_head = bus.wall[r_heading];

    rr_arb4 u_arb (
        .clk     (clk),
        .rst     (rst),
        .request (w_rise),
        .grant   (w_grant)
    );

    always_comb begin
        w_state_next      = r_state;
        w_heading_next    = r_heading;
        w_step_next       = 1'b0;
        w_pend_valid_next = r_pend_valid;
        w_pend_dir_next   = r_pend_dir;
        w_pend_age_next   = r_pend_age;

        if (bus.move_tick) begin
            if (r_pend_valid && !w_wall_pend) begin
                w_heading_next    = r_pend_dir;
                w_pend_valid_next = 1'b0;
                w_pend_age_next   = '0;
                w_state_next      = ST_RUN;
                w_step_next       = 1'b1;
            end else begin
                // A blocked turn ages out but does not stop travel in the current heading.
                if (r_pend_valid) begin
                    if (r_pend_age == c_AGE_LAST) begin
                        w_pend_valid_next = 1'b0;
                        w_pend_age_next   = '0;
                    end else begin
                        w_pend_age_next = r_pend_age + c_AGE_ONE;
                    end
                end
                if (r_state != ST_IDLE) begin
                    if (!w_wall_head) begin
                        w_step_next  = 1'b1;
                        w_state_next = ST_RUN;
                    end else begin
                        w_state_next = ST_STALL;
                    end
                end
            end
        end

        // A fresh grant wins over a same-cycle consumption of the older request.
        if (|w_grant) begin
            w_pend_dir_next   = dir_from_onehot(w_grant);
            w_pend_valid_next = 1'b1;
            w_pend_age_next   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_heading    <= DIR_UP;
            r_step       <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_dir   <= DIR_UP;
            r_pend_age   <= '0;
            r_btn_q      <= 4'b0000;
        end else begin
            r_state      <= w_state_next;
            r_heading    <= w_heading_next;
            r_step       <= w_step_next;
            r_pend_valid <= w_pend_valid_next;
            r_pend_dir   <= w_pend_dir_next;
            r_pend_age   <= w_pend_age_next;
            r_btn_q      <= bus.btn;
        end
    end

    assign bus.heading    = r_heading;
    assign bus.moving     = (r_state == ST_RUN);
    // Reset arriving while a step is due cancels it immediately.
    assign bus.step       = r_step & ~rst;
    assign bus.pend_valid = r_pend_valid;

endmodule

`default_nettype wire

// File: tb/tb_dir_ctrl.sv
// ============================================================================
//  Module   : tb_dir_ctrl
//  Purpose  : Directed self-checking bench for dir_ctrl
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dir_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    dir_ctrl_if bus ();

    dir_ctrl #(.PEND_TICKS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input logic [3:0] w);
        bus.wall      = w;
        bus.move_tick = 1'b1;
        cyc();
        bus.move_tick = 1'b0;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.btn       = 4'b0000;
        bus.move_tick = 1'b0;
        bus.wall      = 4'b0000;
        cyc();
        cyc();
        check("rst_heading", 4'(bus.heading), 4'd0);
        check("rst_moving",  4'(bus.moving), 4'd0);
        check("rst_step",    4'(bus.step), 4'd0);
        check("rst_pend",    4'(bus.pend_valid), 4'd0);
        rst = 1'b0;
        cyc();

        // Tick while idle: nothing moves
        tick(4'b0000);
        check("idle_step",   4'(bus.step), 4'd0);
        check("idle_moving", 4'(bus.moving), 4'd0);

        // Press right, tick with open path
        bus.btn = 4'b1000;
        cyc();
        check("right_pend", 4'(bus.pend_valid), 4'd1);
        check("right_step_early", 4'(bus.step), 4'd0);
        tick(4'b0000);
        check("right_heading", 4'(bus.heading), 4'd3);
        check("right_moving",  4'(bus.moving), 4'd1);
        check("right_step",    4'(bus.step), 4'd1);
        check("right_pend_clr", 4'(bus.pend_valid), 4'd0);
        cyc();
        check("right_step_pulse", 4'(bus.step), 4'd0);

        // Up blocked for three ticks, keep stepping right, then turn
        bus.btn = 4'b1001;
        cyc();
        check("up_pend", 4'(bus.pend_valid), 4'd1);
        for (int k = 0; k < 3; k++) begin
            tick(4'b0001);
            check("up_blk_step",    4'(bus.step), 4'd1);
            check("up_blk_heading", 4'(bus.heading), 4'd3);
            check("up_blk_pend",    4'(bus.pend_valid), 4'd1);
            cyc();
        end
        tick(4'b0000);
        check("up_heading", 4'(bus.heading), 4'd0);
        check("up_step",    4'(bus.step), 4'd1);
        check("up_pend_clr", 4'(bus.pend_valid), 4'd0);
        cyc();

        // Left blocked for PEND_TICKS ticks: discarded
        bus.btn = 4'b1101;
        cyc();
        check("left_pend", 4'(bus.pend_valid), 4'd1);
        for (int k = 0; k < 4; k++) begin
            tick(4'b0100);
            check("age_step", 4'(bus.step), 4'd1);
            check("age_pend", 4'(bus.pend_valid), (k < 3) ? 4'd1 : 4'd0);
            cyc();
        end
        check("age_heading", 4'(bus.heading), 4'd0);

        // Heading left, then stall, then resume
        bus.btn = 4'b0000;
        cyc();
        bus.btn = 4'b0100;
        cyc();
        tick(4'b0000);
        check("l_heading", 4'(bus.heading), 4'd2);
        check("l_step",    4'(bus.step), 4'd1);
        cyc();
        tick(4'b0100);
        check("stall_moving",  4'(bus.moving), 4'd0);
        check("stall_step",    4'(bus.step), 4'd0);
        check("stall_heading", 4'(bus.heading), 4'd2);
        cyc();
        tick(4'b0000);
        check("resume_step",   4'(bus.step), 4'd1);
        check("resume_moving", 4'(bus.moving), 4'd1);

        // Back-to-back ticks
        tick(4'b0000);
        check("b2b_step1", 4'(bus.step), 4'd1);
        tick(4'b0000);
        check("b2b_step2", 4'(bus.step), 4'd1);
        cyc();
        check("b2b_step_end", 4'(bus.step), 4'd0);

        // Rise coincident with a tick consuming the older request
        bus.btn = 4'b0000;
        cyc();
        bus.btn = 4'b1000;
        cyc();
        bus.btn = 4'b1100;
        tick(4'b0000);
        check("sim_heading", 4'(bus.heading), 4'd3);
        check("sim_pend",    4'(bus.pend_valid), 4'd1);
        tick(4'b0000);
        check("sim_heading2", 4'(bus.heading), 4'd2);
        check("sim_pend2",    4'(bus.pend_valid), 4'd0);

        // Reset right after an accepted turn kills the step
        bus.btn = 4'b0000;
        cyc();
        bus.btn = 4'b0010;
        cyc();
        tick(4'b0000);
        check("pre_rst_step", 4'(bus.step), 4'd1);
        rst = 1'b1;
        #1;
        check("rst_kill_step", 4'(bus.step), 4'd0);
        bus.btn = 4'b0011;
        cyc();
        check("rst2_heading", 4'(bus.heading), 4'd0);
        check("rst2_moving",  4'(bus.moving), 4'd0);
        check("rst2_step",    4'(bus.step), 4'd0);
        check("rst2_pend",    4'(bus.pend_valid), 4'd0);

        // Held buttons through reset: up then down via round robin
        rst = 1'b0;
        cyc();
        check("rr_pend", 4'(bus.pend_valid), 4'd1);
        tick(4'b0000);
        check("rr_up_heading", 4'(bus.heading), 4'd0);
        check("rr_up_step",    4'(bus.step), 4'd1);
        bus.btn = 4'b0000;
        cyc();
        bus.btn = 4'b0011;
        cyc();
        tick(4'b0000);
        check("rr_down_heading", 4'(bus.heading), 4'd1);

        // Reversal down -> up
        bus.btn = 4'b0000;
        cyc();
        bus.btn = 4'b0001;
        cyc();
        tick(4'b0000);
        check("rev_heading", 4'(bus.heading), 4'd0);
        check("rev_step",    4'(bus.step), 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dir_ctrl.md
DIR_CTRL -- requirements
Module: dir_ctrl

Interface
REQ-001 Parameter PEND_TICKS, default 4: number of move_tick pulses a blocked pending turn is held before it is discarded.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 btn  input  4  debounced, synchronised button levels; [0]=up, [1]=down, [2]=left, [3]=right.
REQ-005 move_tick  input  1  one-cycle pulse marking a movement decision point.
REQ-006 wall  input  4  wall-present flags per direction from the current tile, same bit order as btn; sampled only on move_tick.
REQ-007 heading  output  2  committed direction: 0=up, 1=down, 2=left, 3=right.
REQ-008 moving  output  1  high in RUN state.
REQ-009 step  output  1  one-cycle pulse commanding a one-tile move in heading.
REQ-010 pend_valid  output  1  a turn request is buffered.

Function
REQ-011 Edge detect: rise = btn & ~btn_q; btn_q registers btn every cycle.
REQ-012 If more than one rise bit is set in a cycle, a 4-way round-robin arbiter grants exactly one; the pointer starts at up and advances to grant+1 (mod 4) after each grant.
REQ-013 A grant loads pend_dir and sets pend_valid in the next cycle, overwriting any older pending request and clearing pend_age.
REQ-014 States: IDLE (no heading yet), RUN (moving), STALL (heading blocked); only move_tick causes transitions.
REQ-015 On move_tick with pend_valid and wall[pend_dir]=0: heading<=pend_dir, pend_valid<=0, state<=RUN, step=1 in the following cycle.
REQ-016 On move_tick with pend_valid and wall[pend_dir]=1: pending retained, pend_age increments; when pend_age reaches PEND_TICKS the pending request is cleared.
REQ-017 On move_tick not consuming a pending request: in RUN/STALL, wall[heading]=0 -> step=1, state<=RUN; wall[heading]=1 -> no step, state<=STALL; in IDLE, stay IDLE, no step.
REQ-018 Reversal (pend_dir opposite heading) follows REQ-015 with no special case.
REQ-019 step latency: exactly one cycle after the move_tick cycle; never asserted in IDLE; at most one step per move_tick.
REQ-020 Simultaneous rise and move_tick: the tick decision uses the pending value from before the cycle; the new grant then loads pend_dir and leaves pend_valid=1 even if the tick consumed the old request.
REQ-021 move_tick on consecutive cycles is legal; each is evaluated independently.

Reset
REQ-022 On rst: state=IDLE, heading=0, moving=0, step=0, pend_valid=0, pend_dir=0, pend_age=0, btn_q=0, arbiter pointer=0.
REQ-023 Since btn_q resets to 0, a button held through reset produces a rise in the first cycle after rst deasserts.
REQ-024 rst asserted mid-operation discards any pending request and suppresses a step due in the next cycle.

Structure
REQ-025 Shared package pacman_pkg holds direction encoding constants (DIR_UP..DIR_RIGHT), the 2-bit direction type, the state encoding and the opposite-direction function.
REQ-026 Round-robin arbiter is a separate sub-module rr_arb4 (request[3:0] -> one-hot grant, pointer internal, same clk/rst).

Verification
REQ-027 Reset, press right (btn=4'b1000), tick with wall=0 -> heading=3, moving=1, step pulse one cycle after tick.
REQ-028 RUN right, press up with wall[0]=1 for 3 ticks then 0 -> steps right on 3 ticks, heading=0 on 4th tick, pend_valid cleared.
REQ-029 Blocked pending with PEND_TICKS=4, wall[pend] held 1 for 4 ticks -> pend_valid=0 after 4th tick, heading unchanged.
REQ-030 btn=4'b0011 rising together after reset -> up granted; repeat after release -> down granted.
REQ-031 RUN heading=left, wall[2]=1 on tick -> state STALL, moving=0, no step; next tick wall[2]=0 -> step, RUN.
REQ-032 rst asserted on cycle after move_tick with accepted turn -> step stays 0, all outputs at reset values.
